// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues reads to a 1-cycle-latency program
// memory and presents one registered instruction per cycle with stall and redirect.
module fetch_unit #(
  parameter int unsigned          INSTR_WIDTH  = 16,
  parameter int unsigned          PC_WIDTH     = 10,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [PC_WIDTH-1:0]    pmem_addr,
  output logic                   pmem_rd,
  input  logic [INSTR_WIDTH-1:0] pmem_data,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic                   redirect_abs_en,
  input  logic [11:0]            redirect_offset,
  input  logic [PC_WIDTH-1:0]    redirect_abs,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic [PC_WIDTH-1:0]    return_pc
);

  localparam int unsigned OFFSET_WIDTH = 12;

  logic [PC_WIDTH-1:0]    fetch_pc_q,    fetch_pc_d;
  logic                   inflight_q,    inflight_d;
  logic [PC_WIDTH-1:0]    inflight_pc_q, inflight_pc_d;
  logic                   skid_valid_q,  skid_valid_d;
  logic [INSTR_WIDTH-1:0] skid_data_q,   skid_data_d;
  logic [PC_WIDTH-1:0]    skid_pc_q,     skid_pc_d;
  logic [INSTR_WIDTH-1:0] instr_q,       instr_d;
  logic                   instr_valid_q, instr_valid_d;
  logic [PC_WIDTH-1:0]    instr_pc_q,    instr_pc_d;

  logic                   redirect_take;
  logic                   rd_req;
  logic [31:0]            offset_ext;
  logic [PC_WIDTH-1:0]    target_pc;

  // Redirect is only meaningful against a valid instruction; it beats stall.
  assign redirect_take = redirect_valid && instr_valid_q;
  assign rd_req        = !stall && !redirect_take;

  assign offset_ext = {{(32 - OFFSET_WIDTH){redirect_offset[OFFSET_WIDTH-1]}}, redirect_offset};
  assign target_pc  = redirect_abs_en ? redirect_abs
                    : PC_WIDTH'(32'(instr_pc_q) + 32'd1 + offset_ext);

  // Read strobe is forced low while reset is asserted.
  assign pmem_rd     = rst_n && rd_req;
  assign pmem_addr   = fetch_pc_q;
  assign instruction = instr_q;
  assign instr_valid = instr_valid_q;
  assign instr_pc    = instr_pc_q;
  assign return_pc   = PC_WIDTH'(instr_pc_q + 1'b1);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_data_d   = skid_data_q;
    skid_pc_d     = skid_pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    instr_pc_d    = instr_pc_q;

    if (redirect_take) begin
      // Wrong-path read in flight and any skidded word are discarded.
      fetch_pc_d    = target_pc;
      inflight_d    = 1'b0;
      skid_valid_d  = 1'b0;
      instr_valid_d = 1'b0;
    end else begin
      inflight_d = rd_req;
      if (rd_req) begin
        fetch_pc_d    = PC_WIDTH'(fetch_pc_q + 1'b1);
        inflight_pc_d = fetch_pc_q;
      end

      if (stall) begin
        // No read is issued while stalled, so one skid entry always suffices.
        if (inflight_q) begin
          skid_valid_d = 1'b1;
          skid_data_d  = pmem_data;
          skid_pc_d    = inflight_pc_q;
        end
      end else begin
        instr_valid_d = inflight_q || skid_valid_q;
        if (skid_valid_q) begin
          instr_d      = skid_data_q;
          instr_pc_d   = skid_pc_q;
          skid_valid_d = inflight_q;
          if (inflight_q) begin
            skid_data_d = pmem_data;
            skid_pc_d   = inflight_pc_q;
          end
        end else if (inflight_q) begin
          instr_d    = pmem_data;
          instr_pc_d = inflight_pc_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_VECTOR;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      skid_valid_q  <= 1'b0;
      skid_data_q   <= '0;
      skid_pc_q     <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      instr_pc_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_data_q   <= skid_data_d;
      skid_pc_q     <= skid_pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall/skid, relative and absolute
// redirects, PC wrap and mid-stream reset, against a behavioural program memory.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [9:0]  pmem_addr;
  logic        pmem_rd;
  logic [15:0] pmem_data;
  logic        stall;
  logic        redirect_valid;
  logic        redirect_abs_en;
  logic [11:0] redirect_offset;
  logic [9:0]  redirect_abs;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [9:0]  instr_pc;
  logic [9:0]  return_pc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] mem [1024];

  fetch_unit #(
    .INSTR_WIDTH (16),
    .PC_WIDTH    (10),
    .RESET_VECTOR(10'd0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pmem_addr      (pmem_addr),
    .pmem_rd        (pmem_rd),
    .pmem_data      (pmem_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_abs_en(redirect_abs_en),
    .redirect_offset(redirect_offset),
    .redirect_abs   (redirect_abs),
    .instruction    (instruction),
    .instr_valid    (instr_valid),
    .instr_pc       (instr_pc),
    .return_pc      (return_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous program memory, one cycle of read latency.
  always_ff @(posedge clk) begin
    if (pmem_rd) pmem_data <= mem[pmem_addr];
  end

  function automatic logic [15:0] word_at(int a);
    case (a)
      0:       return 16'h0C01;
      1:       return 16'h1C23;
      2:       return 16'h0000;
      3:       return 16'h2C45;
      default: return 16'hA000 | 16'(a);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [9:0] pc);
    chk({tag, ".valid"}, 32'(instr_valid), 32'(v));
    if (v) begin
      chk({tag, ".pc"},    32'(instr_pc),    32'(pc));
      chk({tag, ".instr"}, 32'(instruction), 32'(word_at(int'(pc))));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = word_at(i);
    pmem_data       = 16'h0;
    rst_n           = 1'b0;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_abs_en = 1'b0;
    redirect_offset = 12'h000;
    redirect_abs    = 10'h000;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'(instr_valid), 32'd0);
    chk("rst.pc",    32'(instr_pc),    32'd0);
    chk("rst.instr", 32'(instruction), 32'd0);
    chk("rst.rd",    32'(pmem_rd),     32'd0);
    chk("rst.addr",  32'(pmem_addr),   32'd0);

    // Test 1: reset release, two-cycle latency, one instruction per cycle
    rst_n = 1'b1;
    #1;
    chk("t1.rd0",   32'(pmem_rd),   32'd1);
    chk("t1.addr0", 32'(pmem_addr), 32'd0);
    tick(); expect_out("t1.c1", 1'b0, 10'd0);
    chk("t1.addr1", 32'(pmem_addr), 32'd1);
    tick(); expect_out("t1.c2", 1'b1, 10'd0);
    tick(); expect_out("t1.c3", 1'b1, 10'd1);
    chk("t1.retpc", 32'(return_pc), 32'd2);

    // Test 2: stall three cycles while pc 1 is shown
    stall = 1'b1;
    #1;
    chk("t2.rd_stall", 32'(pmem_rd), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("t2.hold", 1'b1, 10'd1);
      chk("t2.rd_hold", 32'(pmem_rd), 32'd0);
    end
    stall = 1'b0;
    tick(); expect_out("t2.pc2", 1'b1, 10'd2);
    tick(); expect_out("t2.pc3", 1'b1, 10'd3);
    tick(); expect_out("t2.pc4", 1'b1, 10'd4);
    tick(); expect_out("t2.pc5", 1'b1, 10'd5);

    // Test 3: RJMP at pc 5, offset -3 -> target 3
    redirect_valid  = 1'b1;
    redirect_offset = 12'hFFD;
    #1;
    chk("t3.rd_redir", 32'(pmem_rd), 32'd0);
    tick(); expect_out("t3.bub1", 1'b0, 10'd0);
    redirect_valid = 1'b0;
    tick(); expect_out("t3.bub2", 1'b0, 10'd0);
    tick(); expect_out("t3.tgt", 1'b1, 10'd3);
    tick(); expect_out("t3.tgt1", 1'b1, 10'd4);

    // Test 4: fill the skid, then RET while still stalled
    stall = 1'b1;
    tick(); expect_out("t4.hold", 1'b1, 10'd4);
    redirect_valid  = 1'b1;
    redirect_abs_en = 1'b1;
    redirect_abs    = 10'h155;
    tick(); expect_out("t4.bub1", 1'b0, 10'd0);
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_abs_en = 1'b0;
    tick(); expect_out("t4.bub2", 1'b0, 10'd0);
    tick(); expect_out("t4.tgt", 1'b1, 10'h155);
    tick(); expect_out("t4.tgt1", 1'b1, 10'h156);

    // Test 5: fetch across the top of the address space, then RCALL wrapping to 0
    redirect_valid  = 1'b1;
    redirect_abs_en = 1'b1;
    redirect_abs    = 10'h3FE;
    tick(); expect_out("t5.bub1", 1'b0, 10'd0);
    redirect_valid  = 1'b0;
    redirect_abs_en = 1'b0;
    tick(); expect_out("t5.bub2", 1'b0, 10'd0);
    tick(); expect_out("t5.3fe", 1'b1, 10'h3FE);
    chk("t5.ret3fe", 32'(return_pc), 32'h3FF);
    tick(); expect_out("t5.3ff", 1'b1, 10'h3FF);
    chk("t5.ret3ff", 32'(return_pc), 32'h000);
    tick(); expect_out("t5.wrap", 1'b1, 10'h000);
    redirect_valid  = 1'b1;
    redirect_abs_en = 1'b1;
    redirect_abs    = 10'h3FE;
    tick(); expect_out("t5.bub3", 1'b0, 10'd0);
    redirect_valid  = 1'b0;
    redirect_abs_en = 1'b0;
    tick(); expect_out("t5.bub4", 1'b0, 10'd0);
    tick(); expect_out("t5.call_at", 1'b1, 10'h3FE);
    redirect_valid  = 1'b1;
    redirect_offset = 12'h001;
    tick(); expect_out("t5.bub5", 1'b0, 10'd0);
    redirect_valid = 1'b0;
    tick(); expect_out("t5.bub6", 1'b0, 10'd0);
    tick(); expect_out("t5.call_tgt", 1'b1, 10'h000);

    // Test 6: reset mid-stream with the skid occupied
    stall = 1'b1;
    tick(); expect_out("t6.hold", 1'b1, 10'h000);
    rst_n = 1'b0;
    #1;
    chk("t6.valid", 32'(instr_valid), 32'd0);
    chk("t6.pc",    32'(instr_pc),    32'd0);
    chk("t6.instr", 32'(instruction), 32'd0);
    chk("t6.rd",    32'(pmem_rd),     32'd0);
    chk("t6.addr",  32'(pmem_addr),   32'd0);
    stall           = 1'b0;
    redirect_valid  = 1'b1;
    redirect_abs_en = 1'b1;
    redirect_abs    = 10'h200;
    tick(); expect_out("t6.inrst", 1'b0, 10'd0);
    rst_n = 1'b1;
    tick(); expect_out("t6.bub", 1'b0, 10'd0);
    tick(); expect_out("t6.pc0", 1'b1, 10'd0);
    redirect_valid  = 1'b0;
    redirect_abs_en = 1'b0;
    tick(); expect_out("t6.pc1", 1'b1, 10'd1);
    tick(); expect_out("t6.pc2", 1'b1, 10'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
